fft_twiddle_mul_stage: RTL and testbench

- Per-sample complex twiddle multiplier for the folded FFT/CWT datapath.
- Sits directly downstream of the real and imaginary twiddle ROMs. It drives their shared address and consumes their registered outputs, which arrive 1 cycle after the address.
- Multiplies each incoming complex sample by W[idx] and emits the result to the butterfly stage over a valid/ready stream.
- One frame is N_POINTS samples, started by a `start` pulse.

---
 rtl/fft_twiddle_mul_stage.sv | 165 ++++++++++++++++
 tb/tb_fft_twiddle_mul_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_mul_stage.sv
// fft_twiddle_mul_stage
//   Per-sample complex twiddle multiplier for the folded FFT/CWT datapath.
//   Each accepted sample is multiplied by W[idx], where W comes from external
//   real/imag twiddle ROMs that return data one cycle after tw_addr.
//   One frame is N_POINTS samples, started by a start pulse in IDLE.
//
//   Optional build macro: TWIDDLE_ROUND_EN
//     defined   -> round half up (add 2^(FRAC-1)) before the shift, then saturate
//     undefined -> floor (arithmetic shift), then saturate
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 frame start pulse (honoured in IDLE only)
//   in_valid/in_ready     input sample stream, data in_re/in_im
//   tw_addr               address to both twiddle ROMs
//   tw_re/tw_im           registered twiddle ROM outputs
//   out_valid/out_ready   result stream, data out_re/out_im, out_last on idx N_POINTS-1
//   busy                  high in RUN and DRAIN
//   done                  one-cycle pulse after the last result is taken
module fft_twiddle_mul_stage #(
    parameter int N_POINTS = 28,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int FRAC     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic [ADDR_W-1:0] tw_addr,
    input  logic [DATA_W-1:0] tw_re,
    input  logic [DATA_W-1:0] tw_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int SW = 2 * DATA_W + 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(N_POINTS - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(DATA_W - 1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef TWIDDLE_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state;
    // one spare bit so idx can never alias for any N_POINTS <= 2^ADDR_W
    logic [ADDR_W:0] idx;

    logic signed [DATA_W-1:0] hold_re_p0, hold_im_p0;
    logic                     hold_last_p0;
    logic                     vld_p0;      // hold register occupied
    logic                     tw_pend_p0;  // ROM is fetching this sample's twiddle
    logic                     vld_p1;      // tw_re/tw_im now valid for the held sample

    logic signed [DATA_W-1:0] w_re, w_im;
    logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0] sum_re, sum_im;
    logic in_fire, out_fire, load_out;

    function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
`ifdef TWIDDLE_ROUND_EN
        r = (s + RND) >>> FRAC;
`else
        r = s >>> FRAC;
`endif
        if (r > SAT_MAX)
            scale_sat = SAT_MAX[DATA_W-1:0];
        else if (r < SAT_MIN)
            scale_sat = SAT_MIN[DATA_W-1:0];
        else
            scale_sat = r[DATA_W-1:0];
    endfunction

    assign in_ready = (state == RUN) && !vld_p0;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // result may load into an empty output or one being drained this edge
    assign load_out = vld_p1 && (!out_valid || out_ready);

    assign w_re   = tw_re;
    assign w_im   = tw_im;
    assign p_rr   = hold_re_p0 * w_re;
    assign p_ii   = hold_im_p0 * w_im;
    assign p_ri   = hold_re_p0 * w_im;
    assign p_ir   = hold_im_p0 * w_re;
    assign sum_re = SW'(p_rr) - SW'(p_ii);
    assign sum_im = SW'(p_ri) + SW'(p_ir);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            tw_addr      <= '0;
            hold_re_p0   <= '0;
            hold_im_p0   <= '0;
            hold_last_p0 <= 1'b0;
            vld_p0       <= 1'b0;
            tw_pend_p0   <= 1'b0;
            vld_p1       <= 1'b0;
            out_valid    <= 1'b0;
            out_re       <= '0;
            out_im       <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    idx   <= '0;
                end
                RUN: if (in_fire && idx == LAST_IDX) state <= DRAIN;
                DRAIN: if (out_fire && out_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // E0: input handshake, address goes out to the ROMs
            if (in_fire) begin
                hold_re_p0   <= in_re;
                hold_im_p0   <= in_im;
                hold_last_p0 <= (idx == LAST_IDX);
                vld_p0       <= 1'b1;
                tw_pend_p0   <= 1'b1;
                tw_addr      <= idx[ADDR_W-1:0];
                idx          <= idx + 1'b1;
            end

            // E1: ROM output reflects tw_addr
            if (tw_pend_p0) begin
                tw_pend_p0 <= 1'b0;
                vld_p1     <= 1'b1;
            end

            // E2: product into the output register, hold register freed
            if (load_out) begin
                out_re    <= scale_sat(sum_re);
                out_im    <= scale_sat(sum_im);
                out_last  <= hold_last_p0;
                out_valid <= 1'b1;
                vld_p0    <= 1'b0;
                vld_p1    <= 1'b0;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_twiddle_mul_stage.sv
module tb_fft_twiddle_mul_stage;

    localparam int N_POINTS = 28;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int FRAC     = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re, in_im;
    logic [ADDR_W-1:0] tw_addr;
    logic [DATA_W-1:0] tw_re, tw_im;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re, out_im;
    logic              out_last;
    logic              busy;
    logic              done;

    fft_twiddle_mul_stage #(
        .N_POINTS(N_POINTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAC(FRAC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // twiddle ROM model: registered, one cycle after the address
    logic [DATA_W-1:0] rom_re_t [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rom_im_t [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        tw_re <= rom_re_t[tw_addr];
        tw_im <= rom_im_t[tw_addr];
    end

    int checks = 0;
    int passed = 0;

    function automatic logic [DATA_W-1:0] model_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                    input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d,
                                                    input bit sub);
        longint x, y, s;
        x = longint'($signed(a)) * longint'($signed(b));
        y = longint'($signed(c)) * longint'($signed(d));
        s = sub ? x - y : x + y;
`ifdef TWIDDLE_ROUND_EN
        s = s + (longint'(1) << (FRAC - 1));
`endif
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return DATA_W'(s);
    endfunction

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic              last;
    } exp_t;

    // scoreboard: expected result pushed on every input handshake
    exp_t sb[$];
    int   in_idx;
    int   rd;
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n || start) begin
            in_idx = 0;
        end else if (in_valid && in_ready) begin
            e.re   = model_mul(in_re, rom_re_t[in_idx % 32], in_im, rom_im_t[in_idx % 32], 1'b1);
            e.im   = model_mul(in_re, rom_im_t[in_idx % 32], in_im, rom_re_t[in_idx % 32], 1'b0);
            e.last = (in_idx == N_POINTS - 1);
            sb.push_back(e);
            in_idx++;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_re = '0; in_im = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd = sb.size();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_sample(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im, input bit keep);
        int n;
        n = 0;
        in_re = re; in_im = im; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL accept_timeout: in_ready got %b required 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic check_sb_head();
        checks++;
        if (rd >= sb.size()) begin
            $display("FAIL sb_empty: result with no expected entry re=%h im=%h", out_re, out_im);
        end else if (out_re !== sb[rd].re || out_im !== sb[rd].im || out_last !== sb[rd].last) begin
            $display("FAIL sb_result[%0d]: got re=%h im=%h last=%b required re=%h im=%h last=%b",
                     rd, out_re, out_im, out_last, sb[rd].re, sb[rd].im, sb[rd].last);
        end else passed++;
        rd++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_re = 16'h1234; in_im = 16'h5678;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else passed++;
        checks++; if (out_re !== 16'h0) $display("FAIL rst_out_re: got %h required 0000", out_re); else passed++;
        checks++; if (out_im !== 16'h0) $display("FAIL rst_out_im: got %h required 0000", out_im); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b required 0", out_last); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else passed++;
        checks++; if (tw_addr !== 5'd0) $display("FAIL rst_tw_addr: got %0d required 0", tw_addr); else passed++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // in_valid in IDLE must not be accepted
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready: got %b required 0", in_ready); else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        rom_re_t[0] = 16'h0000; rom_im_t[0] = 16'hFF00;
        do_start();
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else passed++;
        drive_sample(16'd100, 16'd50, 1'b0);
        checks++; if (tw_addr !== 5'd0) $display("FAIL basic_tw_addr: got %0d required 0", tw_addr); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_lat_e0: out_valid got %b required 0", out_valid); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_lat_e1: out_valid got %b required 0", out_valid); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_lat_e2: out_valid got %b required 1", out_valid); else passed++;
        checks++; if (out_re !== 16'd50) $display("FAIL basic_re: got %h required 0032", out_re); else passed++;
        checks++; if (out_im !== 16'hFF9C) $display("FAIL basic_im: got %h required ff9c", out_im); else passed++;
        check_sb_head();
    endtask

    task automatic test_saturation();
        apply_reset();
        rom_re_t[0] = 16'hFF00; rom_im_t[0] = 16'hFF00;
        do_start();
        drive_sample(16'h8000, 16'h8000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) $display("FAIL sat_valid: got %b required 1", out_valid); else passed++;
        checks++; if (out_re !== 16'h0000) $display("FAIL sat_re: got %h required 0000", out_re); else passed++;
        checks++; if (out_im !== 16'h7FFF) $display("FAIL sat_im: got %h required 7fff", out_im); else passed++;
        check_sb_head();
    endtask

    task automatic test_rounding();
        logic [DATA_W-1:0] exp_re;
`ifdef TWIDDLE_ROUND_EN
        exp_re = 16'd1;
`else
        exp_re = 16'd0;
`endif
        apply_reset();
        rom_re_t[0] = 16'h0080; rom_im_t[0] = 16'h0000;
        do_start();
        drive_sample(16'd1, 16'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_re !== exp_re) $display("FAIL round_re: got %h required %h", out_re, exp_re); else passed++;
        checks++; if (out_im !== 16'h0000) $display("FAIL round_im: got %h required 0000", out_im); else passed++;
        // negative half: -1 * 0.5 = -0.5 -> floor -1, round half up 0
`ifdef TWIDDLE_ROUND_EN
        exp_re = 16'h0000;
`else
        exp_re = 16'hFFFF;
`endif
        rom_re_t[1] = 16'h0080; rom_im_t[1] = 16'h0000;
        @(posedge clk); #1;
        drive_sample(16'hFFFF, 16'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_re !== exp_re) $display("FAIL round_neg_re: got %h required %h", out_re, exp_re); else passed++;
    endtask

    // full frame with random ROM contents; optional output stall at result stall_at
    task automatic run_frame(input int stall_at);
        int base;
        for (int i = 0; i < 32; i++) begin
            rom_re_t[i] = DATA_W'($urandom);
            rom_im_t[i] = DATA_W'($urandom);
        end
        rd = sb.size();
        base = sb.size();
        out_ready = 1'b1;
        do_start();
        fork
            begin : driver
                for (int i = 0; i < N_POINTS; i++) begin
                    drive_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b1);
                    checks++;
                    if (tw_addr !== ADDR_W'(i)) $display("FAIL frame_tw_addr[%0d]: got %0d required %0d", i, tw_addr, i);
                    else passed++;
                end
                checks++;
                if (in_ready !== 1'b0) $display("FAIL frame_in_ready_after_last: got %b required 0", in_ready);
                else passed++;
            end
            begin : collector
                for (int k = 0; k < N_POINTS; k++) begin
                    int n;
                    n = 0;
                    while (!out_valid && n < 200) begin
                        @(posedge clk); #1; n++;
                    end
                    if (!out_valid) begin
                        checks++;
                        $display("FAIL out_timeout[%0d]: out_valid got 0 required 1", k);
                        break;
                    end
                    if (k == stall_at) begin
                        logic [DATA_W-1:0] s_re, s_im;
                        logic [ADDR_W-1:0] s_addr;
                        int bad;
                        out_ready = 1'b0;
                        n = 0;
                        while (in_ready && n < 10) begin
                            @(posedge clk); #1; n++;
                        end
                        s_re = out_re; s_im = out_im; s_addr = tw_addr;
                        bad = 0;
                        repeat (5) begin
                            @(posedge clk); #1;
                            if (out_valid !== 1'b1 || out_re !== s_re || out_im !== s_im || tw_addr !== s_addr) bad++;
                        end
                        checks++;
                        if (bad != 0) $display("FAIL stall_stable: got %0d changed cycles required 0 (re=%h im=%h addr=%0d)",
                                               bad, out_re, out_im, tw_addr);
                        else passed++;
                        out_ready = 1'b1;
                    end
                    check_sb_head();
                    @(posedge clk); #1;
                end
                checks++;
                if (done !== 1'b1) $display("FAIL done_pulse: got %b required 1", done); else passed++;
                checks++;
                if (busy !== 1'b0) $display("FAIL busy_after_frame: got %b required 0", busy); else passed++;
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0) $display("FAIL done_width: got %b required 0", done); else passed++;
            end
        join
        in_valid = 1'b0;
        checks++;
        if (sb.size() - base != N_POINTS) $display("FAIL frame_accept_count: got %0d required %0d", sb.size() - base, N_POINTS);
        else passed++;
    endtask

    task automatic test_full_frame();
        apply_reset();
        run_frame(-1);
    endtask

    task automatic test_back_pressure();
        apply_reset();
        run_frame(6);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            rom_re_t[i] = DATA_W'($urandom);
            rom_im_t[i] = DATA_W'($urandom);
        end
        do_start();
        for (int i = 0; i <= 10; i++) drive_sample(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b required 0", out_valid); else passed++;
        checks++; if (out_re !== 16'h0 || out_im !== 16'h0) $display("FAIL mid_out_data: got %h/%h required 0000/0000", out_re, out_im); else passed++;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL mid_state: busy=%b in_ready=%b required 0/0", busy, in_ready); else passed++;
        checks++; if (tw_addr !== 5'd0 || done !== 1'b0) $display("FAIL mid_addr_done: tw_addr=%0d done=%b required 0/0", tw_addr, done); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL mid_no_done: got %b required 0", done); else passed++;
        run_frame(-1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_full_frame();
        test_back_pressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
